// File: rtl/rgd_requester_if.sv
// Job intake and RGD handshake signals of one requester; master is the requester side,
// slave is the local job source plus the arbiter.
interface rgd_requester_if #(
  parameter int LEN_W = 8
);
  logic             job_valid;
  logic             job_ready;
  logic [LEN_W-1:0] job_len;
  logic             r;
  logic             d;
  logic             g;
  logic             use_active;
  logic             job_done;
  logic             proto_err;
  logic             timeout_err;

  modport master (
    input  job_valid, job_len, g,
    output job_ready, r, d, use_active, job_done, proto_err, timeout_err
  );

  modport slave (
    output job_valid, job_len, g,
    input  job_ready, r, d, use_active, job_done, proto_err, timeout_err
  );
endinterface

// File: rtl/rgd_requester.sv
// Requester end of the four-phase Request-Grant-Done handshake, with a synchronised grant.
// Optional grant-wait timeout flag enabled by defining RGD_TIMEOUT_EN.
module rgd_requester #(
  parameter int SYNC_STAGES = 2,
  parameter int LEN_W       = 8,
  parameter int TO_W        = 12,
  parameter int TO_LIMIT    = 1000
) (
  input  logic                   clk,
  input  logic                   rstn,
  rgd_requester_if.master        bus
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || TO_LIMIT < 1 || TO_LIMIT >= (2 ** TO_W)) begin : g_bad_param
    $error("rgd_requester: illegal SYNC_STAGES or TO_LIMIT");
  end

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    USE     = 3'd2,
    DONE    = 3'd3,
    RELEASE = 3'd4
  } state_t;

  state_t                 state;
  logic [LEN_W-1:0]       cnt;
  logic [SYNC_STAGES-1:0] g_sync;
  logic                   g_s;
  logic                   job_ready_q;
  logic                   r_q;
  logic                   d_q;
  logic                   use_q;
  logic                   done_q;
  logic                   perr_q;
  logic                   accept;
  logic [LEN_W-1:0]       len_eff;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      g_sync <= '0;
    end else begin
      g_sync <= {g_sync[SYNC_STAGES-2:0], bus.g};
    end
  end

  assign g_s     = g_sync[SYNC_STAGES-1];
  assign accept  = bus.job_valid && job_ready_q;
  assign len_eff = (bus.job_len == '0) ? LEN_W'(1) : bus.job_len;

  // job_ready is already high in RELEASE so a waiting job can re-request after a single low cycle of r.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      cnt         <= '0;
      job_ready_q <= 1'b0;
      r_q         <= 1'b0;
      d_q         <= 1'b0;
      use_q       <= 1'b0;
      done_q      <= 1'b0;
      perr_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          job_ready_q <= 1'b1;
          if (g_s) begin
            perr_q <= 1'b1;
          end
          if (accept) begin
            state       <= REQ;
            cnt         <= len_eff;
            r_q         <= 1'b1;
            job_ready_q <= 1'b0;
          end
        end
        REQ: begin
          if (g_s) begin
            state <= USE;
            use_q <= 1'b1;
          end
        end
        USE: begin
          // A grant withdrawn mid-use is flagged but the use period still completes.
          if (!g_s) begin
            perr_q <= 1'b1;
          end
          cnt <= cnt - 1'b1;
          if (cnt == LEN_W'(1)) begin
            state <= DONE;
            use_q <= 1'b0;
            d_q   <= 1'b1;
          end
        end
        DONE: begin
          if (!g_s) begin
            state       <= RELEASE;
            r_q         <= 1'b0;
            d_q         <= 1'b0;
            done_q      <= 1'b1;
            job_ready_q <= 1'b1;
          end
        end
        RELEASE: begin
          if (g_s) begin
            perr_q <= 1'b1;
          end
          if (accept) begin
            state       <= REQ;
            cnt         <= len_eff;
            r_q         <= 1'b1;
            job_ready_q <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          r_q         <= 1'b0;
          d_q         <= 1'b0;
          use_q       <= 1'b0;
          job_ready_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef RGD_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt;
  logic            to_err_q;

  // Counter holds the index of the current REQ cycle, so the entry cycle is preloaded as the first.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      to_cnt   <= '0;
      to_err_q <= 1'b0;
    end else if (state != REQ || g_s) begin
      to_cnt   <= TO_W'(1);
      to_err_q <= 1'b0;
    end else begin
      if (to_cnt != TO_W'(TO_LIMIT)) begin
        to_cnt <= to_cnt + 1'b1;
      end
      to_err_q <= (to_cnt >= TO_W'(TO_LIMIT - 1));
    end
  end

  assign bus.timeout_err = to_err_q;
`else
  assign bus.timeout_err = 1'b0;
`endif

  assign bus.job_ready  = job_ready_q;
  assign bus.r          = r_q;
  assign bus.d          = d_q;
  assign bus.use_active = use_q;
  assign bus.job_done   = done_q;
  assign bus.proto_err  = perr_q;

endmodule

// File: tb/tb_rgd_requester.sv
module tb_rgd_requester;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  rgd_requester_if #(.LEN_W(8)) bus ();

  logic auto_arb = 1'b0;
  logic g_man    = 1'b0;
  logic g_arb    = 1'b0;
  assign bus.g = auto_arb ? g_arb : g_man;
  always @(posedge clk) g_arb <= bus.r & ~bus.d;

  rgd_requester #(
    .SYNC_STAGES(2),
    .LEN_W(8),
    .TO_W(12),
    .TO_LIMIT(20)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    bus.job_valid = 1'b0;
    bus.job_len = '0;
    repeat (3) step();
    checks++;
    if (bus.job_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_job_ready: got %b expected 0", bus.job_ready);
    end
    checks++;
    if ({bus.r, bus.d, bus.use_active, bus.job_done, bus.proto_err, bus.timeout_err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 000000",
               {bus.r, bus.d, bus.use_active, bus.job_done, bus.proto_err, bus.timeout_err});
    end
    rstn = 1'b1;
    step();
    checks++;
    if (bus.job_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: got %b expected 1", bus.job_ready);
    end
  endtask

  task automatic test_basic();
    logic [1:0] exp_ud;
    logic [2:0] exp_rdd;
    bus.job_len = 8'd3;
    bus.job_valid = 1'b1;
    step();
    bus.job_valid = 1'b0;
    checks++;
    if (bus.r !== 1'b1) begin
      errors++;
      $display("FAIL basic_r_cycle1: got %b expected 1", bus.r);
    end
    repeat (3) step();
    g_man = 1'b1;
    for (int c = 5; c <= 10; c++) begin
      step();
      exp_ud = {(c >= 7 && c <= 9), (c == 10)};
      checks++;
      if ({bus.use_active, bus.d} !== exp_ud) begin
        errors++;
        $display("FAIL basic_use_d cycle %0d: got %b expected %b", c, {bus.use_active, bus.d}, exp_ud);
      end
    end
    repeat (2) step();
    g_man = 1'b0;
    for (int c = 13; c <= 16; c++) begin
      step();
      exp_rdd = (c <= 14) ? 3'b110 : ((c == 15) ? 3'b001 : 3'b000);
      checks++;
      if ({bus.r, bus.d, bus.job_done} !== exp_rdd) begin
        errors++;
        $display("FAIL basic_release cycle %0d: got r,d,done=%b expected %b", c,
                 {bus.r, bus.d, bus.job_done}, exp_rdd);
      end
    end
    checks++;
    if (bus.proto_err !== 1'b0) begin
      errors++;
      $display("FAIL basic_proto_err: got %b expected 0", bus.proto_err);
    end
  endtask

  task automatic test_back_to_back();
    int acc = 0, dones = 0, uses = 0, cur_run = 0, max_run = 0;
    int rises = 0, low_run = 0, gap = -1;
    logic pend, r_prev;
    auto_arb = 1'b1;
    bus.job_len = 8'd0;
    bus.job_valid = 1'b1;
    pend = bus.job_valid && bus.job_ready;
    r_prev = bus.r;
    for (int i = 0; i < 60; i++) begin
      step();
      if (pend) begin
        acc++;
        if (acc == 1) bus.job_len = 8'd1;
        else bus.job_valid = 1'b0;
      end
      if (bus.job_done === 1'b1) dones++;
      if (bus.use_active === 1'b1) begin
        uses++;
        cur_run++;
        if (cur_run > max_run) max_run = cur_run;
      end else begin
        cur_run = 0;
      end
      if (bus.r === 1'b1) begin
        if (!r_prev) begin
          if (rises > 0) gap = low_run;
          rises++;
        end
        low_run = 0;
      end else begin
        low_run++;
      end
      r_prev = bus.r;
      pend = bus.job_valid && bus.job_ready;
    end
    auto_arb = 1'b0;
    checks++;
    if (dones != 2 || acc != 2) begin
      errors++;
      $display("FAIL b2b_jobs: got done=%0d accepted=%0d expected 2 and 2", dones, acc);
    end
    checks++;
    if (uses != 2 || max_run != 1) begin
      errors++;
      $display("FAIL b2b_use: got total=%0d longest=%0d expected 2 and 1", uses, max_run);
    end
    checks++;
    if (gap != 1) begin
      errors++;
      $display("FAIL b2b_r_gap: got %0d low cycles expected 1", gap);
    end
  endtask

  task automatic test_max_len();
    int uses = 0;
    logic seen_done = 1'b0;
    auto_arb = 1'b1;
    bus.job_len = 8'hFF;
    bus.job_valid = 1'b1;
    step();
    bus.job_valid = 1'b0;
    for (int i = 0; i < 400 && !seen_done; i++) begin
      step();
      if (bus.use_active === 1'b1) uses++;
      if (bus.job_done === 1'b1) seen_done = 1'b1;
    end
    auto_arb = 1'b0;
    checks++;
    if (!seen_done || uses != 255) begin
      errors++;
      $display("FAIL max_len: got use cycles=%0d done=%b expected 255 and 1", uses, seen_done);
    end
  endtask

  task automatic test_delayed_grant();
    int bad = 0, to_bad = 0, n;
    logic exp_to;
    bus.job_len = 8'd2;
    bus.job_valid = 1'b1;
    step();
    bus.job_valid = 1'b0;
    for (int c = 1; c <= 54; c++) begin
      if (c == 51) g_man = 1'b1;
      if (c <= 50 && {bus.r, bus.d, bus.use_active} !== 3'b100) bad++;
`ifdef RGD_TIMEOUT_EN
      exp_to = (c >= 20 && c <= 53);
`else
      exp_to = 1'b0;
`endif
      if (bus.timeout_err !== exp_to) to_bad++;
      if (c >= 51) begin
        checks++;
        if ({bus.r, bus.use_active} !== {1'b1, (c == 54)}) begin
          errors++;
          $display("FAIL delayed_use cycle %0d: got r,use=%b expected 1%b", c,
                   {bus.r, bus.use_active}, (c == 54));
        end
      end
      if (c < 54) step();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL delayed_hold: got %0d bad cycles expected 0", bad);
    end
    checks++;
    if (to_bad != 0) begin
      errors++;
      $display("FAIL delayed_timeout_err: got %0d mismatching cycles expected 0", to_bad);
    end
    n = 0;
    while (bus.d !== 1'b1 && n < 20) begin step(); n++; end
    g_man = 1'b0;
    n = 0;
    while (bus.job_done !== 1'b1 && n < 20) begin step(); n++; end
    checks++;
    if (bus.job_done !== 1'b1) begin
      errors++;
      $display("FAIL delayed_done: got no job_done within budget expected pulse");
    end
  endtask

  task automatic test_proto_violation();
    int uses = 0, n;
    g_man = 1'b1;
    step();
    g_man = 1'b0;
    step();
    checks++;
    if (bus.proto_err !== 1'b0) begin
      errors++;
      $display("FAIL proto_early: got %b expected 0", bus.proto_err);
    end
    step();
    checks++;
    if ({bus.proto_err, bus.job_ready, bus.r} !== 3'b110) begin
      errors++;
      $display("FAIL proto_idle_grant: got err,ready,r=%b expected 110",
               {bus.proto_err, bus.job_ready, bus.r});
    end
    repeat (2) step();
    bus.job_len = 8'd10;
    bus.job_valid = 1'b1;
    step();
    bus.job_valid = 1'b0;
    g_man = 1'b1;
    for (int i = 0; i < 60 && bus.d !== 1'b1; i++) begin
      step();
      if (bus.use_active === 1'b1) uses++;
      if (uses == 4) g_man = 1'b0;
    end
    checks++;
    if (uses != 10 || bus.d !== 1'b1) begin
      errors++;
      $display("FAIL proto_use_len: got use cycles=%0d d=%b expected 10 and 1", uses, bus.d);
    end
    n = 0;
    while (bus.job_done !== 1'b1 && n < 20) begin step(); n++; end
    step();
    checks++;
    if (bus.proto_err !== 1'b1) begin
      errors++;
      $display("FAIL proto_sticky: got %b expected 1", bus.proto_err);
    end
  endtask

  task automatic test_reset_mid_job();
    int n = 0;
    bus.job_len = 8'd1;
    bus.job_valid = 1'b1;
    step();
    bus.job_valid = 1'b0;
    g_man = 1'b1;
    while (bus.d !== 1'b1 && n < 30) begin step(); n++; end
    checks++;
    if ({bus.r, bus.d, bus.proto_err} !== 3'b111) begin
      errors++;
      $display("FAIL mid_before_reset: got r,d,err=%b expected 111", {bus.r, bus.d, bus.proto_err});
    end
    @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    checks++;
    if ({bus.r, bus.d, bus.proto_err} !== 3'b000) begin
      errors++;
      $display("FAIL mid_async_reset: got r,d,err=%b expected 000", {bus.r, bus.d, bus.proto_err});
    end
    g_man = 1'b0;
    repeat (2) step();
    rstn = 1'b1;
    step();
    checks++;
    if ({bus.job_ready, bus.use_active, bus.r} !== 3'b100) begin
      errors++;
      $display("FAIL mid_recover: got ready,use,r=%b expected 100",
               {bus.job_ready, bus.use_active, bus.r});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_max_len();
    test_delayed_grant();
    test_proto_violation();
    test_reset_mid_job();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
